sram_sp_masked_init_ext: RTL and testbench
==========================================

Name: sram_sp_masked_init_ext

Overview:
Parametrised single-port synchronous SRAM macro model for the memory library. It is the generalised successor of the fixed 256x64 unmasked single-port arrays. It adds configurable depth and width, a per-lane write mask and read-data hold. It also has a hardware clear sequencer that zeroes every row after reset and holds off requests until the clear finishes. It is instantiated under cache and predictor tables wherever a deterministic post-reset memory image is required.

Parameters:
DEPTH, 256, number of rows; any integer >= 2, power of two not required
WIDTH, 64, data bits per row
MASK_GRAN, 8, bits per write-mask lane; WIDTH must be an integer multiple of MASK_GRAN
ADDR_W, clog2(DEPTH), address width; derived, not overridden
MASK_W, WIDTH/MASK_GRAN, mask lanes; derived

Ports:
RW0_clk  input  1  clock; all state updates on rising edge
RW0_reset  input  1  asynchronous, active-high reset
RW0_addr  input  ADDR_W  row address for read or write
RW0_en  input  1  request valid
RW0_wmode  input  1  1 = write, 0 = read; sampled only when RW0_en=1
RW0_wdata  input  WIDTH  write data
RW0_wmask  input  MASK_W  write lane enable; bit i covers wdata[i*MASK_GRAN +: MASK_GRAN]
RW0_rdata  output  WIDTH  read data, one cycle after an accepted read, held until next accepted read
RW0_ready  output  1  1 = requests are accepted; 0 during clear sequence

Behaviour:
- Reset asserted, asynchronously: state=CLEAR, clear pointer=0, RW0_ready=0, RW0_rdata=0. Array contents are not touched by reset itself.
- FSM has two states: CLEAR and IDLE.
- CLEAR state:
  - Each rising edge writes all-zero to row[ptr] with every lane enabled, then increments ptr.
  - On the edge that writes row DEPTH-1: go to IDLE, RW0_ready becomes 1, ptr returns to 0.
  - Clear takes exactly DEPTH edges after reset deassertion. RW0_ready rises after edge DEPTH.
- In CLEAR, RW0_en is ignored: no write, no read, RW0_rdata stays 0.
- Reset asserted mid-clear: restart from ptr=0. Reset asserted in IDLE: re-enter CLEAR and re-zero the full array.
- Accepted request = RW0_en & RW0_ready.
- Write (accepted, wmode=1):
  - At the edge, for each lane i with wmask[i]=1, row[addr] lane i <= wdata lane i. Lanes with mask 0 are unchanged.
  - wmask all-zero is a legal no-op.
  - RW0_rdata is unchanged by a write.
- Read (accepted, wmode=0):
  - Address registered at the edge. RW0_rdata = row[registered addr] from that edge onward, i.e. 1-cycle latency.
  - rdata is driven from an output register loaded at the edge after the read, not from a combinational array lookup. A later write to the same row does not alter the held rdata.
- Idle cycles (RW0_en=0, or not ready): RW0_rdata holds its last value. There is no garbage or randomised output.
- Back-to-back:
  - Read every cycle: new data every cycle.
  - Write at cycle N then read of the same addr at cycle N+1: returns the new data; the write is visible next cycle.
- Address >= DEPTH (non-power-of-two DEPTH only): write dropped, read returns 0. No wrap to a lower row.
- RW0_wmask and RW0_wdata are don't-care on reads. RW0_wmode is don't-care when RW0_en=0.
- Simulation-only randomised initial contents are allowed under the existing RANDOMIZE_MEM_INIT macro. After the clear sequence every row must read 0 regardless.

Test Plan:
- Reset defaults: assert reset, release, count edges -> RW0_ready=0 for edges 1..255, 1 after edge 256 (DEPTH=256). Reads of addr 0, 128, 255 then return 64'h0; RW0_rdata=0 throughout the clear.
- Masked write: write addr 5 data 64'h1111_2222_3333_4444 mask 8'hFF, then addr 5 data 64'hAAAA_BBBB_CCCC_DDDD mask 8'h0F, read 5 -> 64'h1111_2222_CCCC_DDDD one cycle after the read request.
- Hold and write-after-read: read addr 5, then 4 idle cycles, then write addr 5 with full mask -> RW0_rdata unchanged throughout. Back-to-back write 9 / read 9 -> new data on the following cycle.
- Ignored during clear: during clear cycles 10..20, drive en=1 wmode=1 addr 3 data all-ones -> after ready, read 3 returns 0. A read issued in the same window produces no rdata change.
- Reset mid-clear: assert reset at clear edge 100, release -> ready rises exactly 256 edges after the second release. Pre-written rows from before the first reset read 0.
- Non-power-of-two: DEPTH=200, WIDTH=32, MASK_GRAN=16 -> ready after 200 edges. Write addr 199 succeeds. Write addr 250 then read 250 -> 0, and row 250 mod 200 = 50 still reads 0.

Source files
------------

// File: rtl/sram_sp_masked_init_ext.sv
// Single-port synchronous SRAM model with per-lane write mask, held read data and
// a post-reset clear sequencer that zeroes every row before requests are accepted.
module sram_sp_masked_init_ext #(
    parameter int  DEPTH     = 256,
    parameter int  WIDTH     = 64,
    parameter int  MASK_GRAN = 8,
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int MASK_W    = WIDTH / MASK_GRAN
) (
    input  logic              RW0_clk,
    input  logic              RW0_reset,
    input  logic [ADDR_W-1:0] RW0_addr,
    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [WIDTH-1:0]  RW0_wdata,
    input  logic [MASK_W-1:0] RW0_wmask,
    output logic [WIDTH-1:0]  RW0_rdata,
    output logic              RW0_ready
);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              ready_q;
    logic [WIDTH-1:0]  rdata_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              addr_ok;
    logic              accept;
    logic              do_read;
    logic              we_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [WIDTH-1:0]  wdata_d;
    logic [MASK_W-1:0] wmask_d;

    // Only a non-power-of-two depth leaves address codes with no backing row.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_pow2
            assign addr_ok = 1'b1;
        end else begin : g_npow2
            assign addr_ok = (RW0_addr <= ADDR_W'(DEPTH - 1));
        end
    endgenerate

    assign accept  = RW0_en & ready_q;
    assign do_read = accept & ~RW0_wmode;

    // The clear sequencer owns the write port until it hands over to IDLE.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = RW0_addr;
        wdata_d = RW0_wdata;
        wmask_d = RW0_wmask;
        if (state_q == ST_CLEAR) begin
            we_d    = ~RW0_reset;
            waddr_d = ptr_q;
            wdata_d = '0;
            wmask_d = '1;
        end else if (accept && RW0_wmode && addr_ok) begin
            we_d = 1'b1;
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (we_d) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wmask_d[i]) begin
                    mem_q[waddr_d][i*MASK_GRAN +: MASK_GRAN] <= wdata_d[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                        ptr_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (do_read) begin
                        rdata_q <= addr_ok ? mem_q[RW0_addr] : '0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ptr_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign RW0_rdata = rdata_q;
    assign RW0_ready = ready_q;

endmodule

// File: tb/tb_sram_sp_masked_init_ext.sv
// Scoreboard bench: a 256x64/8 instance (A) and a 200x32/16 instance (B) share one clock;
// expected read data is queued at issue time and popped by per-instance monitors.
module tb_sram_sp_masked_init_ext;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b0, a_en = 1'b0, a_wmode = 1'b0;
    logic [7:0]  a_addr = '0;
    logic [63:0] a_wdata = '0;
    logic [7:0]  a_wmask = '0;
    logic [63:0] a_rdata;
    logic        a_ready;

    logic        b_rst = 1'b0, b_en = 1'b0, b_wmode = 1'b0;
    logic [7:0]  b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic [1:0]  b_wmask = '0;
    logic [31:0] b_rdata;
    logic        b_ready;

    sram_sp_masked_init_ext #(.DEPTH(256), .WIDTH(64), .MASK_GRAN(8)) u_a (
        .RW0_clk(clk), .RW0_reset(a_rst), .RW0_addr(a_addr), .RW0_en(a_en),
        .RW0_wmode(a_wmode), .RW0_wdata(a_wdata), .RW0_wmask(a_wmask),
        .RW0_rdata(a_rdata), .RW0_ready(a_ready)
    );

    sram_sp_masked_init_ext #(.DEPTH(200), .WIDTH(32), .MASK_GRAN(16)) u_b (
        .RW0_clk(clk), .RW0_reset(b_rst), .RW0_addr(b_addr), .RW0_en(b_en),
        .RW0_wmode(b_wmode), .RW0_wdata(b_wdata), .RW0_wmask(b_wmask),
        .RW0_rdata(b_rdata), .RW0_ready(b_ready)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] qa[$];
    logic [31:0] qb[$];

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitors: an accepted read pops the next expectation; otherwise rdata must hold.
    logic        a_acc = 1'b0, b_acc = 1'b0;
    logic [63:0] a_hold = '0;
    logic [31:0] b_hold = '0;

    always @(posedge clk) begin
        a_acc <= a_en && a_ready && !a_wmode && !a_rst;
        b_acc <= b_en && b_ready && !b_wmode && !b_rst;
    end

    always @(negedge clk) begin
        if (a_acc) begin
            chk(qa.size() != 0, "A_unexpected_read", a_rdata, '0);
            if (qa.size() != 0) a_hold = qa.pop_front();
        end
        if (a_rst) a_hold = '0;
        chk(a_rdata === a_hold, "A_rdata", a_rdata, a_hold);
    end

    always @(negedge clk) begin
        if (b_acc) begin
            chk(qb.size() != 0, "B_unexpected_read", {32'h0, b_rdata}, '0);
            if (qb.size() != 0) b_hold = qb.pop_front();
        end
        if (b_rst) b_hold = '0;
        chk(b_rdata === b_hold, "B_rdata", {32'h0, b_rdata}, {32'h0, b_hold});
    end

    task automatic drive(input bit sel, input bit en, input bit wm, input int addr,
                         input logic [63:0] d, input logic [7:0] m);
        if (!sel) begin
            a_en = en; a_wmode = wm; a_addr = addr[7:0]; a_wdata = d; a_wmask = m;
        end else begin
            b_en = en; b_wmode = wm; b_addr = addr[7:0]; b_wdata = d[31:0]; b_wmask = m[1:0];
        end
    endtask

    task automatic cyc(input bit sel, input bit en, input bit wm, input int addr,
                       input logic [63:0] d, input logic [7:0] m);
        drive(sel, en, wm, addr, d, m);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel, input int addr, input logic [63:0] d, input logic [7:0] m);
        $display("%s WR addr=%0d data=%h mask=%h", sel ? "B" : "A", addr, d, m);
        cyc(sel, 1'b1, 1'b1, addr, d, m);
    endtask

    task automatic rd(input bit sel, input int addr, input logic [63:0] exp);
        $display("%s RD addr=%0d expect=%h", sel ? "B" : "A", addr, exp);
        if (!sel) qa.push_back(exp);
        else      qb.push_back(exp[31:0]);
        cyc(sel, 1'b1, 1'b0, addr, '0, '0);
    endtask

    task automatic idle(input bit sel, input int n);
        repeat (n) cyc(sel, 1'b0, 1'b0, 0, '0, '0);
    endtask

    task automatic set_rst(input bit sel, input bit v);
        if (!sel) a_rst = v;
        else      b_rst = v;
    endtask

    // Pulse reset, then count clear edges; optionally poke requests into the clear window
    // or stop after edge abort_at so the caller can re-assert reset mid-clear.
    task automatic reset_and_clear(input bit sel, input int n, input bit poke, input int abort_at);
        bit rdy;
        $display("%s RESET clear_edges=%0d abort_at=%0d", sel ? "B" : "A", n, abort_at);
        drive(sel, 1'b0, 1'b0, 0, '0, '0);
        set_rst(sel, 1'b1);
        @(posedge clk);
        #1;
        set_rst(sel, 1'b0);
        for (int k = 1; k <= n; k++) begin
            if (poke && k >= 10 && k <= 20) drive(sel, 1'b1, (k != 15), 3, '1, '1);
            else                            drive(sel, 1'b0, 1'b0, 0, '0, '0);
            @(posedge clk);
            #1;
            rdy = sel ? b_ready : a_ready;
            chk(rdy === (k == n), $sformatf("%s_ready_edge%0d", sel ? "B" : "A", k),
                {63'h0, rdy}, {63'h0, (k == n)});
            if (k == abort_at) return;
        end
        drive(sel, 1'b0, 1'b0, 0, '0, '0);
    endtask

    initial begin
        #1;
        a_rst = 1'b1;
        b_rst = 1'b1;
        @(posedge clk);
        #1;

        // Instance A: clear with ignored requests, then clear image
        reset_and_clear(1'b0, 256, 1'b1, 0);
        rd(1'b0, 0, 64'h0);
        rd(1'b0, 128, 64'h0);
        rd(1'b0, 255, 64'h0);
        rd(1'b0, 3, 64'h0);

        // Masked write and read-back, then hold across idles and a write to the same row
        wr(1'b0, 5, 64'h1111_2222_3333_4444, 8'hFF);
        wr(1'b0, 5, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
        rd(1'b0, 5, 64'h1111_2222_CCCC_DDDD);
        idle(1'b0, 4);
        wr(1'b0, 5, 64'h0123_4567_89AB_CDEF, 8'hFF);
        idle(1'b0, 2);

        // Write-then-read, zero-mask no-op, back-to-back reads, top-lane-only write
        wr(1'b0, 9, 64'hFEDC_BA98_7654_3210, 8'hFF);
        rd(1'b0, 9, 64'hFEDC_BA98_7654_3210);
        wr(1'b0, 9, 64'h0, 8'h00);
        rd(1'b0, 9, 64'hFEDC_BA98_7654_3210);
        rd(1'b0, 5, 64'h0123_4567_89AB_CDEF);
        rd(1'b0, 9, 64'hFEDC_BA98_7654_3210);
        rd(1'b0, 5, 64'h0123_4567_89AB_CDEF);
        wr(1'b0, 9, 64'h5555_5555_5555_5555, 8'h80);
        rd(1'b0, 9, 64'h55DC_BA98_7654_3210);
        idle(1'b0, 3);

        // Reset from IDLE, abort at clear edge 100, full clear after second release
        reset_and_clear(1'b0, 256, 1'b0, 100);
        reset_and_clear(1'b0, 256, 1'b0, 0);
        rd(1'b0, 5, 64'h0);
        rd(1'b0, 9, 64'h0);
        rd(1'b0, 3, 64'h0);
        idle(1'b0, 3);

        // Instance B: non-power-of-two depth, out-of-range address handling
        reset_and_clear(1'b1, 200, 1'b0, 0);
        wr(1'b1, 199, 64'hDEAD_BEEF, 8'h03);
        wr(1'b1, 250, 64'hFFFF_FFFF, 8'h03);
        rd(1'b1, 199, 64'hDEAD_BEEF);
        rd(1'b1, 250, 64'h0);
        rd(1'b1, 50, 64'h0);
        wr(1'b1, 7, 64'h1234_5678, 8'h03);
        wr(1'b1, 7, 64'hAAAA_BBBB, 8'h01);
        rd(1'b1, 7, 64'h1234_BBBB);
        idle(1'b1, 3);

        chk(qa.size() == 0, "A_reads_outstanding", 64'(qa.size()), 64'h0);
        chk(qb.size() == 0, "B_reads_outstanding", 64'(qb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
